// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU, one operation in flight.
// Define ALU_ARB_RR_EN to get round-robin between simultaneous requests; otherwise requester 0 wins.
module alu_arbiter #(
    parameter int OP_W = 6,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [DW-1:0]   req0_a,
    input  logic [DW-1:0]   req0_b,
    input  logic [OP_W-1:0] req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [DW-1:0]   req1_a,
    input  logic [DW-1:0]   req1_b,
    input  logic [OP_W-1:0] req1_op,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [DW-1:0]   rsp0_data,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [DW-1:0]   rsp1_data,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [DW-1:0]   alu_c
);

    // state | meaning
    // IDLE  | waiting for a request; ready offered to the granted requester
    // EXEC  | latched operands on the ALU, result captured at cycle end
    // RESP  | result offered to the owner until it takes it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [DW-1:0]   res_q, res_d;
    logic            live_q;
    logic            grant_id;
    logic            accept;
    logic            owner_rsp_ready;
    logic            exec_out;
    logic            resp_out;

`ifdef ALU_ARB_RR_EN
    logic prio_q, prio_d;

    always_comb begin
        grant_id = (req0_valid && req1_valid) ? prio_q : !req0_valid;
        prio_d   = accept ? !grant_id : prio_q;
    end

    always_ff @(posedge clk) begin
        if (rst) prio_q <= 1'b0;
        else     prio_q <= prio_d;
    end
`else
    always_comb begin
        grant_id = !req0_valid;
    end
`endif

    // live_q keeps every requester stalled for the first cycle out of reset
    assign accept          = (state_q == IDLE) && live_q && !rst && (req0_valid || req1_valid);
    assign req0_ready      = accept && !grant_id;
    assign req1_ready      = accept && grant_id;
    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = grant_id;
                    a_d     = grant_id ? req1_a  : req0_a;
                    b_d     = grant_id ? req1_b  : req0_b;
                    op_d    = grant_id ? req1_op : req0_op;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_c;
                state_d = RESP;
            end
            RESP: begin
                if (owner_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            live_q  <= 1'b1;
        end
    end

    assign exec_out   = (state_q == EXEC) && !rst;
    assign resp_out   = (state_q == RESP) && !rst;
    assign alu_a      = exec_out ? a_q  : '0;
    assign alu_b      = exec_out ? b_q  : '0;
    assign alu_op     = exec_out ? op_q : '0;
    assign rsp0_valid = resp_out && !owner_q;
    assign rsp1_valid = resp_out && owner_q;
    assign rsp0_data  = rsp0_valid ? res_q : '0;
    assign rsp1_data  = rsp1_valid ? res_q : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, corner sequences, random vs. timeline model.
module tb_alu_arbiter;
    localparam int OP_W = 6;
    localparam int DW   = 32;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [OP_W-1:0] req0_op, req1_op;
    logic            rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [DW-1:0]   rsp0_data, rsp1_data;
    logic [DW-1:0]   alu_a, alu_b, alu_c;
    logic [OP_W-1:0] alu_op;

    alu_arbiter #(.OP_W(OP_W), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c)
    );

    // Stand-in for the shared ALU
    function automatic logic [DW-1:0] alu_fn(input logic [OP_W-1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            6'd5:    return a + b;
            6'd19:   return a - b;
            6'd13:   return a & b;
            6'd28:   return b;
            6'd9:    return a | b;
            6'd2:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    assign alu_c = alu_fn(alu_op, alu_a, alu_b);

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic            id;
        logic [OP_W-1:0] op;
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [DW-1:0]   exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1; rsp1_ready = 1;
    endtask

    task automatic drv_req(input logic id, input logic [OP_W-1:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        if (id == 1'b0) begin
            req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".req0_ready"}, req0_ready, 0);
        chk({tag, ".req1_ready"}, req1_ready, 0);
        chk({tag, ".rsp0_valid"}, rsp0_valid, 0);
        chk({tag, ".rsp1_valid"}, rsp1_valid, 0);
        chk({tag, ".rsp0_data"}, rsp0_data, 0);
        chk({tag, ".rsp1_data"}, rsp1_data, 0);
        chk({tag, ".alu_a"}, alu_a, 0);
        chk({tag, ".alu_b"}, alu_b, 0);
        chk({tag, ".alu_op"}, alu_op, 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        req0_valid = 1; req1_valid = 1;
        rst = 1;
        tick(); settle();
        chk_quiet("in_reset");
        tick();
        rst = 0;
        settle();
        chk_quiet("post_reset");
        tick();
        idle_inputs();
        settle();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("vec%0d", idx);
        tick(); idle_inputs(); drv_req(v.id, v.op, v.a, v.b); settle();
        chk({t, ".ready_own"}, v.id ? req1_ready : req0_ready, 1);
        chk({t, ".ready_other"}, v.id ? req0_ready : req1_ready, 0);
        // EXEC: both requesters valid with different operands; must not disturb the operation
        tick(); idle_inputs();
        drv_req(0, 6'h3F, ~v.a, ~v.b); drv_req(1, 6'h3F, ~v.a, ~v.b); settle();
        chk({t, ".alu_a"}, alu_a, v.a);
        chk({t, ".alu_b"}, alu_b, v.b);
        chk({t, ".alu_op"}, alu_op, v.op);
        chk({t, ".exec_ready0"}, req0_ready, 0);
        chk({t, ".exec_ready1"}, req1_ready, 0);
        tick(); settle();
        chk({t, ".rsp_valid_own"}, v.id ? rsp1_valid : rsp0_valid, 1);
        chk({t, ".rsp_data_own"}, v.id ? rsp1_data : rsp0_data, v.exp);
        chk({t, ".rsp_valid_other"}, v.id ? rsp0_valid : rsp1_valid, 0);
        chk({t, ".rsp_data_other"}, v.id ? rsp0_data : rsp1_data, 0);
        chk({t, ".resp_ready0"}, req0_ready, 0);
        chk({t, ".resp_ready1"}, req1_ready, 0);
        chk({t, ".resp_alu_op"}, alu_op, 0);
        tick(); idle_inputs(); settle();
        chk({t, ".idle_rsp0"}, rsp0_valid, 0);
        chk({t, ".idle_rsp1"}, rsp1_valid, 0);
        drv_req(v.id, v.op, v.a, v.b); settle();
        chk({t, ".idle_ready"}, v.id ? req1_ready : req0_ready, 1);
        idle_inputs(); settle();
    endtask

    task automatic seq_both();
        int grants[$];
        int rsp0_seen, rsp1_seen;
        int exp_g;
        rsp0_seen = 0; rsp1_seen = 0;
        do_reset();
        tick(); idle_inputs();
        drv_req(0, 6'd19, 32'd10, 32'd3);
        drv_req(1, 6'd13, 32'hF0, 32'h3C);
        settle();
        for (int c = 0; c < 20; c++) begin
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp0_valid) begin rsp0_seen++; chk("both.rsp0_data", rsp0_data, 32'd7); end
            if (rsp1_valid) begin rsp1_seen++; chk("both.rsp1_data", rsp1_data, 32'h30); end
            if (grants.size() >= 4) break;
            tick(); settle();
        end
        chk("both.grant_count", grants.size(), 4);
        for (int i = 0; i < grants.size() && i < 4; i++) begin
            exp_g = RR ? (i % 2) : 0;
            chk($sformatf("both.grant%0d", i), grants[i], exp_g);
        end
        chk("both.rsp0_seen", rsp0_seen, RR ? 2 : 3);
        chk("both.rsp1_seen", rsp1_seen, RR ? 1 : 0);
        tick(); idle_inputs();
        for (int c = 0; c < 4; c++) tick();
        settle();
    endtask

    task automatic seq_hold();
        tick(); idle_inputs(); drv_req(1, 6'd28, 32'h55, 32'h12345000); rsp1_ready = 0; settle();
        chk("hold.req1_ready", req1_ready, 1);
        tick(); req1_valid = 0; drv_req(0, 6'd5, 32'd3, 32'd4); settle();
        chk("hold.exec_req0_ready", req0_ready, 0);
        for (int k = 0; k < 5; k++) begin
            tick(); settle();
            chk($sformatf("hold.rsp1_valid%0d", k), rsp1_valid, 1);
            chk($sformatf("hold.rsp1_data%0d", k), rsp1_data, 32'h12345000);
            chk($sformatf("hold.req0_ready%0d", k), req0_ready, 0);
        end
        tick(); rsp1_ready = 1; settle();
        chk("hold.rel_valid", rsp1_valid, 1);
        chk("hold.rel_data", rsp1_data, 32'h12345000);
        chk("hold.rel_req0_ready", req0_ready, 0);
        tick(); settle();
        chk("hold.after_valid", rsp1_valid, 0);
        chk("hold.after_req0_ready", req0_ready, 1);
        idle_inputs(); settle();
    endtask

    task automatic seq_rst();
        tick(); idle_inputs(); drv_req(0, 6'd9, 32'hF0, 32'h0F); settle();
        chk("rst.req0_ready", req0_ready, 1);
        tick(); req0_valid = 0; settle();
        chk("rst.exec_op", alu_op, 9);
        rst = 1; settle();
        chk_quiet("rst.during");
        tick(); rst = 0;
        drv_req(0, 6'd5, 32'd3, 32'd4); drv_req(1, 6'd13, 32'hF0, 32'h3C); settle();
        chk_quiet("rst.first_after");
        tick(); settle();
        chk("rst.grant0", req0_ready, 1);
        chk("rst.grant1", req1_ready, 0);
        chk("rst.no_rsp0", rsp0_valid, 0);
        tick(); idle_inputs(); settle();
        chk("rst.new_op", alu_op, 5);
        chk("rst.no_rsp0_exec", rsp0_valid, 0);
        tick(); settle();
        chk("rst.new_rsp0", rsp0_valid, 1);
        chk("rst.new_data", rsp0_data, 32'd7);
        tick(); settle();
    endtask

    // Timeline model: an accepted op at cycle h is on the ALU at h+1 and offered from h+2 until taken.
    task automatic run_random(input int ncyc);
        logic [OP_W-1:0] ops[8];
        bit   pend;
        int   owner, hs_cyc, last_grant, g;
        logic [DW-1:0]   p_a, p_b, p_res;
        logic [OP_W-1:0] p_op;
        bit   e_r0, e_r1, e_rv0, e_rv1, offering;
        ops = '{6'd5, 6'd19, 6'd13, 6'd28, 6'd9, 6'd2, 6'd63, 6'd0};
        do_reset();
        pend = 0; owner = 0; hs_cyc = 0; last_grant = 1; g = 0;
        p_a = '0; p_b = '0; p_op = '0; p_res = '0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            tick();
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_a = $urandom; req0_b = $urandom; req0_op = ops[$urandom_range(0, 7)];
            req1_a = $urandom; req1_b = $urandom; req1_op = ops[$urandom_range(0, 7)];
            rsp0_ready = $urandom_range(0, 1);
            rsp1_ready = $urandom_range(0, 1);
            settle();
            e_r0 = 0; e_r1 = 0;
            if (!pend && (req0_valid || req1_valid)) begin
                if (req0_valid && req1_valid) g = (RR && last_grant == 0) ? 1 : 0;
                else g = req0_valid ? 0 : 1;
                if (g == 0) e_r0 = 1; else e_r1 = 1;
            end
            offering = pend && (cyc >= hs_cyc + 2);
            e_rv0 = offering && owner == 0;
            e_rv1 = offering && owner == 1;
            chk("rnd.req0_ready", req0_ready, e_r0);
            chk("rnd.req1_ready", req1_ready, e_r1);
            chk("rnd.rsp0_valid", rsp0_valid, e_rv0);
            chk("rnd.rsp1_valid", rsp1_valid, e_rv1);
            chk("rnd.rsp0_data", rsp0_data, e_rv0 ? p_res : 0);
            chk("rnd.rsp1_data", rsp1_data, e_rv1 ? p_res : 0);
            chk("rnd.alu_a", alu_a, (pend && cyc == hs_cyc + 1) ? p_a : 0);
            chk("rnd.alu_b", alu_b, (pend && cyc == hs_cyc + 1) ? p_b : 0);
            chk("rnd.alu_op", alu_op, (pend && cyc == hs_cyc + 1) ? p_op : 0);
            if (e_r0 || e_r1) begin
                pend = 1; owner = g; hs_cyc = cyc; last_grant = g;
                p_a  = g ? req1_a : req0_a;
                p_b  = g ? req1_b : req0_b;
                p_op = g ? req1_op : req0_op;
                p_res = alu_fn(p_op, p_a, p_b);
            end else if (offering && (owner == 0 ? rsp0_ready : rsp1_ready)) begin
                pend = 0;
            end
        end
        tick(); idle_inputs();
        for (int c = 0; c < 4; c++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 6'd5,  32'd3,         32'd4,         32'd7};
        vecs[1] = '{1'b1, 6'd5,  32'd100,       32'd23,        32'd123};
        vecs[2] = '{1'b0, 6'd19, 32'd10,        32'd3,         32'd7};
        vecs[3] = '{1'b1, 6'd13, 32'hF0,        32'h3C,        32'h30};
        vecs[4] = '{1'b0, 6'd28, 32'hDEAD,      32'h12345000,  32'h12345000};
        vecs[5] = '{1'b1, 6'd63, 32'd1,         32'd2,         32'd0};
        vecs[6] = '{1'b0, 6'd2,  32'hFF00FF00,  32'h0F0F0F0F,  32'hF00FF00F};
        vecs[7] = '{1'b1, 6'd9,  32'hF0,        32'h0F,        32'hFF};

        do_reset();
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
        seq_both();
        seq_hold();
        seq_rst();
        run_random(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
